// File: rtl/pe_feed_ctrl.sv
// PE operand feeder: streams neuron/weight chunks from the buffers into a PE,
// then captures the PE sum and returns it through a valid/ready handshake.
module pe_feed_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_n,
    input  logic [ADDR_W-1:0] cfg_base_w,
    input  logic [CNT_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic              nram_rd_en,
    output logic              wram_rd_en,
    output logic [ADDR_W-1:0] nram_addr,
    output logic [ADDR_W-1:0] wram_addr,
    input  logic [511:0]      nram_rdata,
    input  logic [511:0]      wram_rdata,
    output logic [511:0]      pe_neuron,
    output logic [511:0]      pe_weight,
    output logic [1:0]        pe_ctl,
    output logic              pe_vld,
    input  logic [31:0]       pe_result,
    input  logic              pe_vld_o,
    output logic [31:0]       res_data,
    output logic              res_vld,
    input  logic              res_rdy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  w_idx_nx;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  w_len_nx;
    logic [ADDR_W-1:0] r_addr_n;
    logic [ADDR_W-1:0] w_addr_n_nx;
    logic [ADDR_W-1:0] r_addr_w;
    logic [ADDR_W-1:0] w_addr_w_nx;
    logic              r_rd_en;
    logic              w_rd_en_nx;
    logic              r_pe_vld;
    logic [1:0]        r_pe_ctl;
    logic [31:0]       r_res_data;
    logic [31:0]       w_res_data_nx;
    logic              r_res_vld;
    logic              w_res_vld_nx;
    logic              r_done;
    logic              w_done_nx;
    logic              w_last;
    logic              w_first;

    assign w_last  = (r_idx == (r_len - CNT_W'(1)));
    assign w_first = (r_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_len      <= '0;
            r_addr_n   <= '0;
            r_addr_w   <= '0;
            r_rd_en    <= 1'b0;
            r_res_data <= '0;
            r_res_vld  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_len      <= w_len_nx;
            r_addr_n   <= w_addr_n_nx;
            r_addr_w   <= w_addr_w_nx;
            r_rd_en    <= w_rd_en_nx;
            r_res_data <= w_res_data_nx;
            r_res_vld  <= w_res_vld_nx;
            r_done     <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_idx_nx      = r_idx;
        w_len_nx      = r_len;
        w_addr_n_nx   = r_addr_n;
        w_addr_w_nx   = r_addr_w;
        w_rd_en_nx    = r_rd_en;
        w_res_data_nx = r_res_data;
        w_res_vld_nx  = r_res_vld;
        w_done_nx     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && (cfg_len != '0)) begin
                    w_state_nx  = S_RUN;
                    w_len_nx    = cfg_len;
                    w_idx_nx    = '0;
                    w_addr_n_nx = cfg_base_n;
                    w_addr_w_nx = cfg_base_w;
                    w_rd_en_nx  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_rd_en_nx = 1'b0;
                    w_state_nx = S_WAIT;
                end else begin
                    w_idx_nx    = r_idx + CNT_W'(1);
                    w_addr_n_nx = r_addr_n + ADDR_W'(1);
                    w_addr_w_nx = r_addr_w + ADDR_W'(1);
                end
            end
            S_WAIT: begin
                if (pe_vld_o) begin
                    w_res_data_nx = pe_result;
                    w_res_vld_nx  = 1'b1;
                    w_state_nx    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_rdy) begin
                    w_res_vld_nx = 1'b0;
                    w_done_nx    = 1'b1;
                    w_state_nx   = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // operand tags follow the read by one cycle, matching buffer latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pe_vld <= 1'b0;
            r_pe_ctl <= 2'b00;
        end else begin
            r_pe_vld <= r_rd_en;
            r_pe_ctl <= r_rd_en ? {w_last, w_first} : 2'b00;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign nram_rd_en = r_rd_en;
    assign wram_rd_en = r_rd_en;
    assign nram_addr  = r_addr_n;
    assign wram_addr  = r_addr_w;
    assign pe_neuron  = nram_rdata;
    assign pe_weight  = wram_rdata;
    assign pe_vld     = r_pe_vld;
    assign pe_ctl     = r_pe_ctl;
    assign res_data   = r_res_data;
    assign res_vld    = r_res_vld;

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Bench for pe_feed_ctrl: buffer and PE models around the DUT, expected
// cycle timeline and dot-product sum computed per command.
module tb_pe_feed_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   cfg_base_n = '0;
    logic [7:0]   cfg_base_w = '0;
    logic [7:0]   cfg_len = '0;
    logic         busy;
    logic         done;
    logic         nram_rd_en;
    logic         wram_rd_en;
    logic [7:0]   nram_addr;
    logic [7:0]   wram_addr;
    logic [511:0] nram_rdata = '0;
    logic [511:0] wram_rdata = '0;
    logic [511:0] pe_neuron;
    logic [511:0] pe_weight;
    logic [1:0]   pe_ctl;
    logic         pe_vld;
    logic [31:0]  pe_result;
    logic         pe_vld_o;
    logic [31:0]  res_data;
    logic         res_vld;
    logic         res_rdy = 1'b0;

    logic [31:0]  mn [256];
    logic [31:0]  mw [256];
    logic [31:0]  acc;
    logic         pe_done;
    logic         spur = 1'b0;
    logic [31:0]  junk = '0;
    int           n_chk = 0;
    int           n_pass = 0;

    pe_feed_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_base_n (cfg_base_n),
        .cfg_base_w (cfg_base_w),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .done       (done),
        .nram_rd_en (nram_rd_en),
        .wram_rd_en (wram_rd_en),
        .nram_addr  (nram_addr),
        .wram_addr  (wram_addr),
        .nram_rdata (nram_rdata),
        .wram_rdata (wram_rdata),
        .pe_neuron  (pe_neuron),
        .pe_weight  (pe_weight),
        .pe_ctl     (pe_ctl),
        .pe_vld     (pe_vld),
        .pe_result  (pe_result),
        .pe_vld_o   (pe_vld_o),
        .res_data   (res_data),
        .res_vld    (res_vld),
        .res_rdy    (res_rdy)
    );

    always #5 clk = ~clk;

    // buffers: one-cycle read latency
    always @(posedge clk) begin
        if (nram_rd_en) nram_rdata <= {16{mn[nram_addr]}};
        if (wram_rd_en) wram_rdata <= {16{mw[wram_addr]}};
    end

    // PE: multiply-accumulate on low lanes, result one cycle after last chunk
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            pe_done <= 1'b0;
        end else begin
            pe_done <= pe_vld & pe_ctl[1];
            if (pe_vld)
                acc <= (pe_ctl[0] ? 32'd0 : acc)
                       + pe_neuron[31:0] * pe_weight[31:0];
        end
    end

    assign pe_vld_o  = pe_done | spur;
    assign pe_result = pe_done ? acc : junk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [7:0] bn, input logic [7:0] bw,
                           input int len, input int delay);
        logic [31:0] sum;
        logic [7:0]  a;
        int          dc;
        int          hs;
        logic        vld_e;
        logic        rv_e;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_done", 64'(done), 64'(0));
        sum = '0;
        for (int i = 0; i < len; i++)
            sum += mn[bn + 8'(i)] * mw[bw + 8'(i)];
        hs = len + 2 + delay;
        dc = hs + 1;
        start      = 1'b1;
        cfg_base_n = bn;
        cfg_base_w = bw;
        cfg_len    = 8'(len);
        tick();
        for (int c = 0; c <= dc; c++) begin
            start      = (c < dc) && ($urandom_range(0, 2) == 0);
            cfg_base_n = 8'($urandom);
            cfg_base_w = 8'($urandom);
            cfg_len    = 8'($urandom);
            res_rdy    = (c < len + 2) ? 1'($urandom_range(0, 1))
                                       : (c >= hs);
            spur = (c < len || c >= len + 2)
                   && ($urandom_range(0, 3) == 0);
            junk = $urandom;
            chk("busy", 64'(busy), 64'(c < dc));
            chk("done", 64'(done), 64'(c == dc));
            chk("nrd_en", 64'(nram_rd_en), 64'(c < len));
            chk("wrd_en", 64'(wram_rd_en), 64'(c < len));
            if (c < len) begin
                a = bn + 8'(c);
                chk("naddr", 64'(nram_addr), 64'(a));
                a = bw + 8'(c);
                chk("waddr", 64'(wram_addr), 64'(a));
            end
            vld_e = (c >= 1) && (c <= len);
            chk("pe_vld", 64'(pe_vld), 64'(vld_e));
            chk("pe_ctl", 64'(pe_ctl),
                vld_e ? 64'({(c == len), (c == 1)}) : 64'(0));
            if (vld_e) begin
                a = bn + 8'(c - 1);
                chk("pe_neuron", pe_neuron[63:0], {2{mn[a]}});
                a = bw + 8'(c - 1);
                chk("pe_weight", pe_weight[63:0], {2{mw[a]}});
            end
            rv_e = (c >= len + 2) && (c < dc);
            chk("res_vld", 64'(res_vld), 64'(rv_e));
            if (rv_e) chk("res_data", 64'(res_data), 64'(sum));
            tick();
        end
        start   = 1'b0;
        spur    = 1'b0;
        res_rdy = 1'b1;
    endtask

    task automatic run_abort(input logic [7:0] bn, input logic [7:0] bw,
                             input int len, input int k);
        start      = 1'b1;
        cfg_base_n = bn;
        cfg_base_w = bw;
        cfg_len    = 8'(len);
        tick();
        start = 1'b0;
        for (int c = 0; c < k; c++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_nrd", 64'(nram_rd_en), 64'(0));
        chk("rst_wrd", 64'(wram_rd_en), 64'(0));
        chk("rst_naddr", 64'(nram_addr), 64'(0));
        chk("rst_waddr", 64'(wram_addr), 64'(0));
        chk("rst_pe_vld", 64'(pe_vld), 64'(0));
        chk("rst_pe_ctl", 64'(pe_ctl), 64'(0));
        chk("rst_res_vld", 64'(res_vld), 64'(0));
        chk("rst_res_data", 64'(res_data), 64'(0));
        tick();
        rst_n = 1'b1;
        chk("rel_done", 64'(done), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mn[i] = $urandom;
            mw[i] = $urandom;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("r_busy", 64'(busy), 64'(0));
        chk("r_done", 64'(done), 64'(0));
        chk("r_rd_en", 64'(nram_rd_en | wram_rd_en), 64'(0));
        chk("r_pe_vld", 64'(pe_vld), 64'(0));
        chk("r_pe_ctl", 64'(pe_ctl), 64'(0));
        chk("r_res_vld", 64'(res_vld), 64'(0));
        chk("r_res_data", 64'(res_data), 64'(0));
        chk("r_addr", 64'({nram_addr, wram_addr}), 64'(0));
        rst_n = 1'b1;

        run_cmd(8'h10, 8'h80, 4, 0);
        run_cmd(8'h33, 8'h44, 1, 0);
        run_cmd(8'hFE, 8'h05, 3, 0);
        run_cmd(8'h20, 8'hFF, 4, 5);

        start   = 1'b1;
        cfg_len = 8'd0;
        tick();
        start = 1'b0;
        chk("z_busy", 64'(busy), 64'(0));
        chk("z_rd_en", 64'(nram_rd_en), 64'(0));
        tick();
        chk("z_done", 64'(done), 64'(0));
        chk("z_busy2", 64'(busy), 64'(0));

        run_abort(8'h40, 8'h50, 6, 2);
        run_cmd(8'h41, 8'h51, 5, 0);
        run_abort(8'h60, 8'h70, 3, 0);
        run_cmd(8'h61, 8'h71, 2, 1);

        for (int n = 0; n < 25; n++)
            run_cmd(8'($urandom), 8'($urandom),
                    $urandom_range(1, 16), $urandom_range(0, 4));
        run_cmd(8'($urandom), 8'($urandom), 255, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pe_feed_ctrl.md
PE_FEED_CTRL -- requirements
Module: pe_feed_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the neuron/weight buffer address width.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the chunk-count field.
REQ-003 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port start, input, 1 bit: single-cycle command pulse.
REQ-006 Ports cfg_base_n and cfg_base_w, input, ADDR_W each: neuron and weight base addresses.
REQ-007 Port cfg_len, input, CNT_W bits: number of 512-bit chunks in the dot product.
REQ-008 Port busy, output, 1 bit: high from command accept until done.
REQ-009 Port done, output, 1 bit: single-cycle completion pulse.
REQ-010 Ports nram_rd_en and wram_rd_en, output, 1 bit each: buffer read strobes.
REQ-011 Ports nram_addr and wram_addr, output, ADDR_W each: buffer read addresses.
REQ-012 Ports nram_rdata and wram_rdata, input, 512 bits each: read data, valid exactly 1 cycle after the read strobe.
REQ-013 Ports pe_neuron and pe_weight, output, 512 bits each: operands to the PE, driven combinationally from nram_rdata and wram_rdata.
REQ-014 Port pe_ctl, output, 2 bits: bit0 = first chunk (PE restarts partial sum); bit1 = last chunk (PE presents result next cycle).
REQ-015 Port pe_vld, output, 1 bit: operand valid.
REQ-016 Port pe_result, input, 32 bits: PE accumulated sum.
REQ-017 Port pe_vld_o, input, 1 bit: pe_result valid.
REQ-018 Ports res_data (output, 32 bits), res_vld (output, 1 bit) and res_rdy (input, 1 bit): result valid/ready handshake.

Function
REQ-019 The controller SHALL be a state machine with states IDLE, RUN, WAIT and HOLD.
REQ-020 In IDLE with start=1 and cfg_len!=0, the block SHALL latch the bases and length, set busy=1 the next cycle and enter RUN.
REQ-021 A start with cfg_len==0, or any start outside IDLE, SHALL be ignored, with no state change and no done pulse.
REQ-022 In RUN, for i=0..len-1 on consecutive cycles, the block SHALL assert both rd_en strobes with nram_addr=base_n+i and wram_addr=base_w+i, modulo 2^ADDR_W (addresses wrap).
REQ-023 After the read with i=len-1, RUN SHALL exit to WAIT with no idle cycles between reads.
REQ-024 pe_vld SHALL be rd_en delayed by 1 cycle (registered).
REQ-025 pe_ctl SHALL be registered alongside pe_vld: bit0=(i==0), bit1=(i==len-1); len==1 gives pe_ctl=2'b11.
REQ-026 When pe_vld=0, pe_ctl SHALL be 2'b00.
REQ-027 In WAIT, on pe_vld_o=1 the block SHALL register pe_result into res_data, set res_vld=1 the next cycle and enter HOLD.
REQ-028 pe_vld_o SHALL be ignored in IDLE, RUN and HOLD.
REQ-029 In HOLD, res_data and res_vld SHALL stay stable until res_rdy=1.
REQ-030 On the cycle where res_vld&res_rdy=1, the next cycle SHALL have res_vld=0, busy=0, done=1 for exactly one cycle, and state IDLE.
REQ-031 A start arriving in the same cycle as that handshake SHALL be ignored; start is accepted only once the block is in IDLE.
REQ-032 Reference timing with res_rdy held 1 (start accepted at edge T, i.e. state enters RUN at T): reads at T..T+len-1, pe_vld at T+1..T+len, pe_vld_o at T+len+1, res_vld at T+len+2, done at T+len+3.

Reset
REQ-033 On rst_n=0, the block SHALL asynchronously return to IDLE and clear busy, done, nram_rd_en, wram_rd_en, pe_vld, pe_ctl, res_vld, res_data, both addresses and all counters to 0.
REQ-034 Reset mid-operation SHALL abandon the command with no done pulse.
REQ-035 After reset release, the block SHALL accept a new start on the next cycle.

Verification
REQ-036 Scenario: len=4, base_n=0x10, base_w=0x80, res_rdy=1 -> addresses 0x10..0x13 and 0x80..0x83; pe_ctl sequence 01,00,00,10; exactly one res_vld carrying the PE sum; done at T+7.
REQ-037 Scenario: len=1 -> a single pe_vld with pe_ctl=11, then one result and done.
REQ-038 Scenario: base_n=0xFE, len=3 -> nram_addr 0xFE, 0xFF, 0x00.
REQ-039 Scenario: res_rdy=0 for 5 cycles -> res_vld and res_data held constant and busy=1; done 1 cycle after res_rdy rises.
REQ-040 Scenario: start during RUN, and start with len=0 while IDLE -> both ignored; the in-flight command completes unchanged.
REQ-041 Scenario: rst_n low for 1 cycle during RUN -> all outputs 0 immediately, no done; a fresh start after release completes correctly.
